// File: rtl/javk_bus_responder.sv
// JAVK CPU bus target: on-chip RAM plus a 4-byte memory-mapped byte-stream I/O window.
// State advances on the falling clock edge that ends the CPU-driven (rw=1) half of each bus cycle.

module javk_stream_fifo #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic [AW:0]   o_count
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;

    // Caller only pushes when not full (or popping in the same cycle) and only pops when non-empty.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PTR_ONE;
            if (i_pop)  r_rd <= r_rd + PTR_ONE;
            if (i_push && !i_pop)
                r_cnt <= r_cnt + CNT_ONE;
            else if (i_pop && !i_push)
                r_cnt <= r_cnt - CNT_ONE;
        end
    end

    always_ff @(negedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    assign o_head  = (r_cnt != '0) ? r_mem[r_rd] : 8'h00;
    assign o_count = r_cnt;
endmodule

module javk_bus_responder #(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] IO_BASE = 16'hFF00,
    parameter int          FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [7:0]  databus,
    input  logic [15:0] addrbus,
    input  logic        rw,
    input  logic        we,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         r_ram [2**RAM_AW];
    logic [7:0]         r_ram_q;
    logic [7:0]         r_io_q;
    logic               r_sel_ram;
    logic               r_tx_ovf;

    logic               w_is_ram;
    logic               w_is_status;
    logic               w_is_txd;
    logic               w_is_rxd;
    logic [RAM_AW-1:0]  w_ram_addr;
    logic [FIFO_AW:0]   w_tx_cnt;
    logic [FIFO_AW:0]   w_rx_cnt;
    logic [7:0]         w_rx_head;
    logic               w_tx_full;
    logic               w_tx_wr;
    logic               w_tx_pop;
    logic               w_tx_push;
    logic               w_rx_push;
    logic               w_rx_pop;
    logic [7:0]         w_status;
    logic [7:0]         w_io_rd;
    logic [7:0]         w_rdata;

    assign w_is_ram    = (addrbus[15:RAM_AW] == '0);
    assign w_is_status = (addrbus == IO_BASE);
    assign w_is_txd    = (addrbus == IO_BASE + 16'd1);
    assign w_is_rxd    = (addrbus == IO_BASE + 16'd2);
    assign w_ram_addr  = addrbus[RAM_AW-1:0];

    // A drain in the same cycle frees the slot, so a write to a full TX FIFO still lands.
    assign w_tx_full = (w_tx_cnt == FULL_CNT);
    assign w_tx_wr   = we && w_is_txd;
    assign w_tx_pop  = tx_valid && tx_ready;
    assign w_tx_push = w_tx_wr && (!w_tx_full || w_tx_pop);
    assign w_rx_push = rx_valid && rx_ready;
    assign w_rx_pop  = !we && w_is_rxd && (w_rx_cnt != '0);

    assign w_status = {4'(w_rx_cnt), 1'b0, r_tx_ovf, !w_tx_full, (w_rx_cnt != '0)};

    always_comb begin
        w_io_rd = 8'hFF;
        if (w_is_status)
            w_io_rd = w_status;
        else if (w_is_rxd)
            w_io_rd = w_rx_head;
    end

    javk_stream_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_data  (databus),
        .i_pop   (w_tx_pop),
        .o_head  (tx_data),
        .o_count (w_tx_cnt)
    );

    javk_stream_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (rx_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_count (w_rx_cnt)
    );

    assign tx_valid = (w_tx_cnt != '0);
    assign rx_ready = (w_rx_cnt != FULL_CNT);

    // RAM keeps its own unreset read register; the select bit decides which read register drives the bus.
    always_ff @(negedge clk) begin
        if (we && w_is_ram)
            r_ram[w_ram_addr] <= databus;
        if (!we && w_is_ram)
            r_ram_q <= r_ram[w_ram_addr];
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_io_q    <= 8'h00;
            r_sel_ram <= 1'b0;
            r_tx_ovf  <= 1'b0;
        end else begin
            if (!we) begin
                r_sel_ram <= w_is_ram;
                r_io_q    <= w_io_rd;
            end
            if (!we && w_is_status)
                r_tx_ovf <= 1'b0;
            else if (w_tx_wr && w_tx_full && !w_tx_pop)
                r_tx_ovf <= 1'b1;
        end
    end

    assign w_rdata = r_sel_ram ? r_ram_q : r_io_q;
    assign databus = (rst && !rw) ? w_rdata : 8'hzz;
endmodule

// File: tb/tb_javk_bus_responder.sv
// Bench for javk_bus_responder: queue/array model checked every cycle, plus literal expectations per transaction.

module tb_javk_bus_responder;
    localparam logic [15:0] A_IDLE = 16'h4000;
    localparam logic [15:0] A_ST   = 16'hFF00;
    localparam logic [15:0] A_TXD  = 16'hFF01;
    localparam logic [15:0] A_RXD  = 16'hFF02;
    localparam logic [15:0] A_U3   = 16'hFF03;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addrbus;
    logic        rw;
    logic        we;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        rx_ready;
    logic        cpu_en;
    logic [7:0]  cpu_drv;
    wire  [7:0]  databus;

    // Undriven bus reads as FF, which is how a released bus is recognised.
    assign databus = cpu_en ? cpu_drv : 8'hzz;
    pullup pu_databus (databus);

    always #10 clk = ~clk;

    javk_bus_responder dut (
        .clk      (clk),
        .rst      (rst),
        .databus  (databus),
        .addrbus  (addrbus),
        .rw       (rw),
        .we       (we),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    // Literal expectation for the current transaction: 1 bus, 2 tx_data, 3 tx_valid, 4 rx_ready.
    int          lit_kind;
    logic [7:0]  lit_val;
    string       lit_name;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  mram [4096];
    bit          mknown [4096];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    bit          movf;
    logic [7:0]  exp_rd;
    bit          exp_known;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            txq.delete();
            rxq.delete();
            movf      = 1'b0;
            exp_rd    = 8'h00;
            exp_known = 1'b1;
            #1;
            chk("rst_bus_released", databus, 8'hFF);
            chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
            chk("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
            chk("rst_tx_data", tx_data, 8'h00);
        end else begin
            int txn;
            int rxn;
            bit txp;
            bit rxpush;
            int ra;
            txn    = txq.size();
            rxn    = rxq.size();
            txp    = (txn > 0) && tx_ready;
            rxpush = rx_valid && (rxn < 4);
            ra     = int'(addrbus[11:0]);
            if (txp) txq.delete(0);
            if (we) begin
                if (addrbus < 16'h1000) begin
                    mram[ra]   = cpu_drv;
                    mknown[ra] = 1'b1;
                end else if (addrbus == A_TXD) begin
                    if (txn < 4 || txp) txq.push_back(cpu_drv);
                    else movf = 1'b1;
                end
            end else begin
                exp_known = 1'b1;
                if (addrbus < 16'h1000) begin
                    exp_rd    = mram[ra];
                    exp_known = mknown[ra];
                end else if (addrbus == A_ST) begin
                    exp_rd = {4'(rxn), 1'b0, movf, (txn < 4), (rxn > 0)};
                    movf   = 1'b0;
                end else if (addrbus == A_RXD) begin
                    if (rxn > 0) begin
                        exp_rd = rxq[0];
                        rxq.delete(0);
                    end else begin
                        exp_rd = 8'h00;
                    end
                end else begin
                    exp_rd = 8'hFF;
                end
            end
            if (rxpush) rxq.push_back(rx_data);
            #3;
            $display("cycle addr=%04h we=%0d wd=%02h bus=%02h txv=%0d txd=%02h rxr=%0d",
                     addrbus, we, cpu_drv, databus, tx_valid, tx_data, rx_ready);
            if (exp_known) chk("bus_rdata", databus, exp_rd);
            chk("tx_valid", {7'd0, tx_valid}, {7'd0, (txq.size() > 0)});
            if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
            chk("rx_ready", {7'd0, rx_ready}, {7'd0, (rxq.size() < 4)});
            case (lit_kind)
                1: chk(lit_name, databus, lit_val);
                2: chk(lit_name, tx_data, lit_val);
                3: chk(lit_name, {7'd0, tx_valid}, lit_val);
                4: chk(lit_name, {7'd0, rx_ready}, lit_val);
                default: ;
            endcase
        end
    end

    task automatic cycx(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input int kind, input logic [7:0] val, input string nm);
        @(posedge clk);
        #1;
        addrbus  = a;
        we       = w;
        rw       = 1'b1;
        cpu_en   = w;
        cpu_drv  = d;
        lit_kind = kind;
        lit_val  = val;
        lit_name = nm;
        @(negedge clk);
        #1;
        rw     = 1'b0;
        cpu_en = 1'b0;
        #4;
        lit_kind = 0;
    endtask

    task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d);
        cycx(a, w, d, 0, 8'h00, "");
    endtask

    initial begin
        rst = 1'b1; rw = 1'b0; we = 1'b0; addrbus = A_IDLE;
        cpu_en = 1'b0; cpu_drv = 8'h00; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; lit_kind = 0; lit_val = 8'h00; lit_name = "";
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        cyc(16'h0123, 1'b1, 8'h5A);
        cycx(16'h0123, 1'b0, 8'h00, 1, 8'h5A, "ram_rd_0123");
        cyc(16'h0FFF, 1'b0, 8'h00);
        cycx(A_IDLE, 1'b0, 8'h00, 1, 8'hFF, "unmapped_rd");
        cycx(A_U3, 1'b0, 8'h00, 1, 8'hFF, "io3_rd");
        cyc(A_RXD, 1'b1, 8'h77);
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h02, "status_after_ro_wr");

        for (int i = 1; i <= 5; i++) cyc(A_TXD, 1'b1, 8'(i));
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h04, "status_ovf_set");
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h00, "status_ovf_cleared");
        cycx(A_IDLE, 1'b0, 8'h00, 2, 8'h01, "tx_head_01");
        tx_ready = 1'b1;
        for (int i = 2; i <= 4; i++) cycx(A_IDLE, 1'b0, 8'h00, 2, 8'(i), "tx_drain_head");
        cycx(A_IDLE, 1'b0, 8'h00, 3, 8'h00, "tx_drained_empty");
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h02, "status_tx_drained");
        tx_ready = 1'b0;

        rx_valid = 1'b1; rx_data = 8'hA1;
        cyc(A_IDLE, 1'b0, 8'h00);
        rx_data = 8'hB2;
        cyc(A_IDLE, 1'b0, 8'h00);
        rx_valid = 1'b0;
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h23, "status_rx2");
        cycx(A_RXD, 1'b0, 8'h00, 1, 8'hA1, "rx_rd_a1");
        cycx(A_RXD, 1'b0, 8'h00, 1, 8'hB2, "rx_rd_b2");
        cycx(A_RXD, 1'b0, 8'h00, 1, 8'h00, "rx_rd_empty");
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h02, "status_rx_empty");

        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'hC0 + 8'(i);
            cyc(A_IDLE, 1'b0, 8'h00);
        end
        rx_data = 8'hEE;
        cycx(A_IDLE, 1'b0, 8'h00, 4, 8'h00, "rx_full_not_ready");
        rx_valid = 1'b0;
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h43, "status_rx_full");
        for (int i = 0; i < 4; i++) cycx(A_RXD, 1'b0, 8'h00, 1, 8'hC0 + 8'(i), "rx_full_drain");
        cycx(A_RXD, 1'b0, 8'h00, 1, 8'h00, "rx_dropped_byte_absent");

        for (int i = 0; i < 4; i++) cyc(A_TXD, 1'b1, 8'h10 + 8'(i));
        tx_ready = 1'b1;
        cycx(A_TXD, 1'b1, 8'h99, 2, 8'h11, "tx_simul_head");
        tx_ready = 1'b0;
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h00, "status_simul_no_ovf");
        tx_ready = 1'b1;
        cycx(A_IDLE, 1'b0, 8'h00, 2, 8'h12, "tx_simul_drain_12");
        cycx(A_IDLE, 1'b0, 8'h00, 2, 8'h13, "tx_simul_drain_13");
        cycx(A_IDLE, 1'b0, 8'h00, 2, 8'h99, "tx_simul_drain_99");
        cycx(A_IDLE, 1'b0, 8'h00, 3, 8'h00, "tx_simul_empty");
        tx_ready = 1'b0;

        rx_valid = 1'b1; rx_data = 8'hC3;
        cycx(A_RXD, 1'b0, 8'h00, 1, 8'h00, "rx_simul_rd_empty");
        rx_valid = 1'b0;
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h13, "status_rx_simul");
        cycx(A_RXD, 1'b0, 8'h00, 1, 8'hC3, "rx_simul_stored");

        for (int i = 0; i < 3; i++) cyc(A_TXD, 1'b1, 8'h21 + 8'(i));
        cycx(16'h0123, 1'b0, 8'h00, 1, 8'h5A, "ram_rd_before_rst");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        cycx(A_ST, 1'b0, 8'h00, 1, 8'h02, "status_after_rst");
        cycx(16'h0123, 1'b0, 8'h00, 1, 8'h5A, "ram_kept_over_rst");
        cyc(A_IDLE, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
